// File: rtl/wb_data_ram.sv
// Wishbone classic-cycle 32-bit word RAM slave with programmable wait states
// and out-of-range error response.
//
// state  | meaning
// S_IDLE | waiting for CYC_I&STB_I; request latched on accept
// S_WAIT | counting down wait states; abort if master drops CYC/STB
// S_RESP | one-cycle ACK_O / ERR_O, always returns to S_IDLE
module wb_data_ram #(
   parameter int          ADDR_WIDTH  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1,
   parameter bit          ACK_ON_ERR  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   input  logic        WE_I,
   input  logic        STB_I,
   input  logic        CYC_I,
   output logic        ACK_O,
   output logic        ERR_O
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] LP_WS  = 4'(WAIT_STATES);

   logic [31:0]           r_mem [2**ADDR_WIDTH];
   logic [1:0]            r_state;
   logic [3:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic [31:0]           r_wdat;
   logic                  r_we;
   logic                  r_hit;
   logic                  r_ack;
   logic                  r_err;
   logic [31:0]           r_rdat;

   logic                  w_req;
   logic                  w_hit_in;
   logic                  w_enter_resp;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_wdat;
   logic                  w_we;
   logic                  w_hit;
   logic                  w_unused;

   assign w_unused = &{1'b0, ADR_I[1:0]};
   assign w_req    = CYC_I & STB_I;
   // BASE_ADDR is aligned to the RAM size, so a hit is a compare of the upper bits only
   assign w_hit_in = (ADR_I[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

   assign w_enter_resp = ((r_state == S_IDLE) && w_req && (LP_WS == 4'd0)) ||
                         ((r_state == S_WAIT) && w_req && (r_cnt == 4'd1));

   // With zero wait states the transfer completes on the accept edge, before the latches are valid
   assign w_idx  = (r_state == S_IDLE) ? ADR_I[ADDR_WIDTH+1:2] : r_adr;
   assign w_wdat = (r_state == S_IDLE) ? DAT_I    : r_wdat;
   assign w_we   = (r_state == S_IDLE) ? WE_I     : r_we;
   assign w_hit  = (r_state == S_IDLE) ? w_hit_in : r_hit;

   always_ff @(posedge clk) begin
      if (w_enter_resp && w_we && w_hit)
         r_mem[w_idx] <= w_wdat;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_adr   <= '0;
         r_wdat  <= 32'd0;
         r_we    <= 1'b0;
         r_hit   <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdat  <= 32'd0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         if (w_enter_resp) begin
            r_ack  <= w_hit | ACK_ON_ERR;
            r_err  <= ~w_hit;
            r_rdat <= w_hit ? r_mem[w_idx] : 32'd0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_adr   <= ADR_I[ADDR_WIDTH+1:2];
                  r_wdat  <= DAT_I;
                  r_we    <= WE_I;
                  r_hit   <= w_hit_in;
                  r_cnt   <= LP_WS;
                  r_state <= (LP_WS == 4'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!w_req) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd1)
                     r_state <= S_RESP;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ACK_O = r_ack;
   assign ERR_O = r_err;
   assign DAT_O = r_rdat;

endmodule

// File: tb/tb_wb_data_ram.sv
// Bench for wb_data_ram: two instances (1 wait state with ACK on error,
// 3 wait states at a non-zero base without ACK on error) against a word-map model.
module tb_wb_data_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr  [2];
   logic [31:0] dati [2];
   logic [31:0] dato [2];
   logic        we   [2];
   logic        stb  [2];
   logic        cyc  [2];
   logic        ack  [2];
   logic        err  [2];

   int errors = 0;
   int checks = 0;
   int ackc0  = 0;
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   always @(negedge clk) if (ack[0] === 1'b1) ackc0++;

   wb_data_ram #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1), .ACK_ON_ERR(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .ADR_I(adr[0]), .DAT_I(dati[0]), .DAT_O(dato[0]),
      .WE_I(we[0]), .STB_I(stb[0]), .CYC_I(cyc[0]), .ACK_O(ack[0]), .ERR_O(err[0]));

   wb_data_ram #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3), .ACK_ON_ERR(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .ADR_I(adr[1]), .DAT_I(dati[1]), .DAT_O(dato[1]),
      .WE_I(we[1]), .STB_I(stb[1]), .CYC_I(cyc[1]), .ACK_O(ack[1]), .ERR_O(err[1]));

   function automatic logic [31:0] base(input int d);
      return (d == 0) ? 32'h0000_0000 : 32'h0001_0000;
   endfunction
   function automatic int ws(input int d);
      return (d == 0) ? 1 : 3;
   endfunction
   function automatic bit aoe(input int d);
      return (d == 0);
   endfunction
   function automatic bit is_hit(input int d, input logic [31:0] a);
      return (a >= base(d)) && (a < base(d) + 32'h4000);
   endfunction
   function automatic int key_of(input int d, input logic [31:0] a);
      return d * 4096 + int'(((a - base(d)) >> 2) & 32'h0000_0FFF);
   endfunction

   // One complete transfer; expectations come from the word map and the address range rule
   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd, input string nm);
      bit          h;
      bit          seen;
      int          k;
      int          key;
      logic [31:0] exp_d;
      h     = is_hit(d, a);
      key   = key_of(d, a);
      exp_d = 32'd0;
      if (!w && h && mdl.exists(key)) exp_d = mdl[key];
      adr[d] = a; dati[d] = wd; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
      seen = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin adr[d] = $urandom; dati[d] = $urandom; end
         if (ack[d] === 1'b1 || err[d] === 1'b1) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: no ACK/ERR within 40 cycles (dut%0d)", nm, d);
      end else begin
         checks++;
         if (k != ws(d) + 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", nm, k, ws(d) + 1);
         end
         checks++;
         if (ack[d] !== (h || aoe(d))) begin
            errors++;
            $display("FAIL %s_ack: got %b, expected %b", nm, ack[d], (h || aoe(d)));
         end
         checks++;
         if (err[d] !== !h) begin
            errors++;
            $display("FAIL %s_err: got %b, expected %b", nm, err[d], !h);
         end
         if (!w) begin
            checks++;
            if (dato[d] !== exp_d) begin
               errors++;
               $display("FAIL %s_data: got %h, expected %h", nm, dato[d], exp_d);
            end
         end
      end
      if (w && h) mdl[key] = wd;
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0) begin
         errors++;
         $display("FAIL %s_single_pulse: ack=%b err=%b in following cycle, expected 0/0", nm, ack[d], err[d]);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         adr[d] = 32'd0; dati[d] = 32'd0; we[d] = 1'b0; stb[d] = 1'b0; cyc[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dato[d] !== 32'd0) begin
            errors++;
            $display("FAIL reset_dut%0d: ack=%b err=%b dat=%h, expected 0/0/0", d, ack[d], err[d], dato[d]);
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read;
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "t1_wr");
      xfer(0, 1'b0, 32'h10, 32'h0, "t1_rd");
      xfer(1, 1'b1, base(1) + 32'h10, 32'hCAFE_F00D, "t1_wr_d1");
      xfer(1, 1'b0, base(1) + 32'h10, 32'h0, "t1_rd_d1");
   endtask

   task automatic test_addr_lsb;
      xfer(0, 1'b1, 32'h10, 32'h1122_3344, "t2_wr");
      xfer(0, 1'b0, 32'h13, 32'h0, "t2_rd");
   endtask

   task automatic test_back_to_back;
      int c0;
      xfer(0, 1'b1, 32'h0, 32'hA0A0_0000, "t3_wr0");
      xfer(0, 1'b1, 32'h4, 32'hB4B4_0004, "t3_wr4");
      c0 = ackc0;
      xfer(0, 1'b0, 32'h0, 32'h0, "t3_rd0");
      xfer(0, 1'b0, 32'h4, 32'h0, "t3_rd4");
      checks++;
      if (ackc0 - c0 != 2) begin
         errors++;
         $display("FAIL t3_ack_count: got %0d ACK cycles, expected 2", ackc0 - c0);
      end
   endtask

   task automatic test_error;
      xfer(0, 1'b1, 32'h4000, 32'h55, "t4_wr_miss");
      xfer(0, 1'b0, 32'h0, 32'h0, "t4_rd_word0");
      xfer(0, 1'b0, 32'h4000, 32'h0, "t4_rd_miss");
      xfer(1, 1'b1, base(1) + 32'h4000, 32'h55, "t4_wr_miss_d1");
      xfer(1, 1'b0, base(1) - 32'h4, 32'h0, "t4_rd_below_d1");
      xfer(1, 1'b0, base(1) + 32'h10, 32'h0, "t4_rd_intact_d1");
   endtask

   task automatic test_abort;
      bit bad;
      xfer(1, 1'b1, base(1) + 32'h20, 32'h1234_5678, "t5_wr_old");
      adr[1] = base(1) + 32'h20; dati[1] = 32'hA5A5_A5A5; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      bad = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack[1] !== 1'b0 || err[1] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL t5_abort_no_ack: saw ACK/ERR after abort, expected none");
      end
      xfer(1, 1'b0, base(1) + 32'h20, 32'h0, "t5_rd_old");
   endtask

   task automatic test_reset_mid;
      xfer(0, 1'b1, 32'h30, 32'h0BAD_F00D, "t6_wr_old");
      adr[0] = 32'h30; dati[0] = 32'hFFFF_FFFF; we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (ack[0] !== 1'b0) begin
         errors++;
         $display("FAIL t6_ack_in_reset: got %b, expected 0", ack[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin
         errors++;
         $display("FAIL t6_no_resp: ack=%b err=%b, expected 0/0", ack[0], err[0]);
      end
      cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'h30, 32'h0, "t6_rd_old");
      xfer(0, 1'b1, 32'h34, 32'h7777_8888, "t6_wr_after");
      xfer(0, 1'b0, 32'h34, 32'h0, "t6_rd_after");
   endtask

   task automatic test_random;
      int          d;
      bit          w;
      logic [31:0] a;
      for (int n = 0; n < 80; n++) begin
         d = $urandom_range(0, 1);
         w = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) begin
            if (d == 1 && $urandom_range(0, 1) == 1)
               a = base(d) - 32'(4 * $urandom_range(1, 64));
            else
               a = base(d) + 32'h4000 + 32'(4 * $urandom_range(0, 255));
         end else begin
            a = base(d) + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if (!w && !mdl.exists(key_of(d, a))) w = 1'b1;
         end
         xfer(d, w, a, $urandom, "rand");
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_addr_lsb;
      test_back_to_back;
      test_error;
      test_abort;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
